// File: rtl/countdown_timer.sv
// countdown_timer: BCD MM:SS countdown driven by an upstream 1 Hz enable pulse.
// A four-state control FSM (IDLE/RUN/PAUSE/DONE) handles start, stop, clear
// and load. Reaching 00:00 raises a done level and a one-cycle alarm pulse.
//
// Command interface: clear, load, stop and start are levels sampled on every
// rising edge. Priority is clear > load > stop > start. A command that has no
// effect in the current state (load in RUN, stop outside RUN, start in DONE
// or with a 00:00 count) does not act, and the next lower one is considered.
// A decrement on ce happens only in RUN when no command acts that cycle.
module countdown_timer #(
  parameter int MIN_HI_MAX = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] sec_lo_in,
  input  logic [3:0] sec_hi_in,
  input  logic [3:0] min_lo_in,
  input  logic [3:0] min_hi_in,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] MIN_HI_LIMIT = 4'(MIN_HI_MAX);

  state_t     state_q, state_d;
  logic [3:0] sec_lo_q, sec_lo_d;
  logic [3:0] sec_hi_q, sec_hi_d;
  logic [3:0] min_lo_q, min_lo_d;
  logic [3:0] min_hi_q, min_hi_d;
  logic       running_q, running_d;
  logic       done_q, done_d;
  logic       alarm_q, alarm_d;

  // Decremented digits and status of the current count
  logic [3:0] dec_sec_lo, dec_sec_hi, dec_min_lo, dec_min_hi;
  logic       count_zero, count_one;

  function automatic logic [3:0] clamp_digit(input logic [3:0] v,
                                             input logic [3:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  // BCD borrow chain: each digit wraps to its maximum when it borrows
  always_comb begin
    dec_sec_lo = sec_lo_q - 4'd1;
    dec_sec_hi = sec_hi_q;
    dec_min_lo = min_lo_q;
    dec_min_hi = min_hi_q;
    if (sec_lo_q == 4'd0) begin
      dec_sec_lo = 4'd9;
      dec_sec_hi = sec_hi_q - 4'd1;
      if (sec_hi_q == 4'd0) begin
        dec_sec_hi = 4'd5;
        dec_min_lo = min_lo_q - 4'd1;
        if (min_lo_q == 4'd0) begin
          dec_min_lo = 4'd9;
          dec_min_hi = min_hi_q - 4'd1;
        end
      end
    end
    count_zero = (min_hi_q == 4'd0) && (min_lo_q == 4'd0) &&
                 (sec_hi_q == 4'd0) && (sec_lo_q == 4'd0);
    count_one  = (min_hi_q == 4'd0) && (min_lo_q == 4'd0) &&
                 (sec_hi_q == 4'd0) && (sec_lo_q == 4'd1);
  end

  // Next-state, next-count and registered-output decode in priority order
  always_comb begin
    state_d  = state_q;
    sec_lo_d = sec_lo_q;
    sec_hi_d = sec_hi_q;
    min_lo_d = min_lo_q;
    min_hi_d = min_hi_q;
    alarm_d  = 1'b0;

    if (clear) begin
      state_d  = ST_IDLE;
      sec_lo_d = 4'd0;
      sec_hi_d = 4'd0;
      min_lo_d = 4'd0;
      min_hi_d = 4'd0;
    end else if (load && (state_q != ST_RUN)) begin
      state_d  = ST_IDLE;
      sec_lo_d = clamp_digit(sec_lo_in, 4'd9);
      sec_hi_d = clamp_digit(sec_hi_in, 4'd5);
      min_lo_d = clamp_digit(min_lo_in, 4'd9);
      min_hi_d = clamp_digit(min_hi_in, MIN_HI_LIMIT);
    end else if (stop && (state_q == ST_RUN)) begin
      state_d = ST_PAUSE;
    end else if (start && !count_zero &&
                 ((state_q == ST_IDLE) || (state_q == ST_PAUSE))) begin
      state_d = ST_RUN;
    end else if (ce && (state_q == ST_RUN)) begin
      sec_lo_d = dec_sec_lo;
      sec_hi_d = dec_sec_hi;
      min_lo_d = dec_min_lo;
      min_hi_d = dec_min_hi;
      if (count_one) begin
        state_d = ST_DONE;
        alarm_d = 1'b1;
      end
    end

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // State, count and status registers; reset clears everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sec_lo_q  <= 4'd0;
      sec_hi_q  <= 4'd0;
      min_lo_q  <= 4'd0;
      min_hi_q  <= 4'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_lo_q  <= sec_lo_d;
      sec_hi_q  <= sec_hi_d;
      min_lo_q  <= min_lo_d;
      min_hi_q  <= min_hi_d;
      running_q <= running_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
    end
  end

  assign sec_lo    = sec_lo_q;
  assign sec_hi    = sec_hi_q;
  assign min_lo    = min_lo_q;
  assign min_hi    = min_hi_q;
  assign running   = running_q;
  assign done      = done_q;
  assign alarm     = alarm_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed command/ce sequences, each cycle's
// expected {digits, running, done, alarm} pushed to a scoreboard queue and
// compared one time unit after the clock edge that produces it.
module tb_countdown_timer;

  localparam int W = 19;

  logic       clk;
  logic       rst_n;
  logic       ce, start, stop, clear, load;
  logic [3:0] sec_lo_in, sec_hi_in, min_lo_in, min_hi_in;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
  logic       running, done, alarm;
  logic [1:0] state_dbg;

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  countdown_timer #(.MIN_HI_MAX(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .load      (load),
    .sec_lo_in (sec_lo_in),
    .sec_hi_in (sec_hi_in),
    .min_lo_in (min_lo_in),
    .min_hi_in (min_hi_in),
    .sec_lo    (sec_lo),
    .sec_hi    (sec_hi),
    .min_lo    (min_lo),
    .min_hi    (min_hi),
    .running   (running),
    .done      (done),
    .alarm     (alarm),
    .state_dbg (state_dbg)
  );

  // Clock: 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected word from a total-seconds count plus status bits
  function automatic logic [W-1:0] pack_exp(input int secs, input logic r,
                                            input logic d, input logic a);
    int mm;
    int ss;
    logic [3:0] mh, ml, sh, sl;
    mm = secs / 60;
    ss = secs % 60;
    mh = 4'(mm / 10);
    ml = 4'(mm % 10);
    sh = 4'(ss / 10);
    sl = 4'(ss % 10);
    return {mh, ml, sh, sl, r, d, a};
  endfunction

  function automatic logic [W-1:0] observed();
    return {min_hi, min_lo, sec_hi, sec_lo, running, done, alarm};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got mmss=%h r/d/a=%b required mmss=%h r/d/a=%b",
               tag, obs[18:3], obs[2:0], exp[18:3], exp[2:0]);
    end
  endtask

  task automatic set_preset(input logic [3:0] mh, input logic [3:0] ml,
                            input logic [3:0] sh, input logic [3:0] sl);
    min_hi_in = mh;
    min_lo_in = ml;
    sec_hi_in = sh;
    sec_lo_in = sl;
  endtask

  // Drive one cycle: cmd = {clear, load, stop, start}; then compare
  task automatic step(input string tag, input logic c, input logic [3:0] cmd,
                      input int exp_secs, input logic er, input logic ed,
                      input logic ea);
    logic [W-1:0] e;
    ce    = c;
    clear = cmd[3];
    load  = cmd[2];
    stop  = cmd[1];
    start = cmd[0];
    exp_q.push_back(pack_exp(exp_secs, er, ed, ea));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, observed(), e);
  endtask

  localparam logic [3:0] C_NONE  = 4'b0000;
  localparam logic [3:0] C_CLEAR = 4'b1000;
  localparam logic [3:0] C_LOAD  = 4'b0100;
  localparam logic [3:0] C_STOP  = 4'b0010;
  localparam logic [3:0] C_START = 4'b0001;

  initial begin
    logic [W-1:0] e;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    ce = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    set_preset(4'd0, 4'd0, 4'd0, 4'd0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(pack_exp(0, 1'b0, 1'b0, 1'b0));
    e = exp_q.pop_front();
    chk("reset_init", observed(), e);
    rst_n = 1'b1;

    // Load 01:00, start, decrement to 00:50
    set_preset(4'd0, 4'd1, 4'd0, 4'd0);
    step("load_0100", 1'b0, C_LOAD, 60, 1'b0, 1'b0, 1'b0);
    step("start_0100", 1'b0, C_START, 60, 1'b1, 1'b0, 1'b0);
    step("dec_0059", 1'b1, C_NONE, 59, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step("dec_to_0050", 1'b1, C_NONE, 58 - i, 1'b1, 1'b0, 1'b0);
      step("idle_gap", 1'b0, C_NONE, 58 - i, 1'b1, 1'b0, 1'b0);
    end

    // Terminal count with ce held high through and past 00:00
    step("clear_a", 1'b0, C_CLEAR, 0, 1'b0, 1'b0, 1'b0);
    set_preset(4'd0, 4'd0, 4'd0, 4'd3);
    step("load_0003", 1'b0, C_LOAD, 3, 1'b0, 1'b0, 1'b0);
    step("start_0003", 1'b0, C_START, 3, 1'b1, 1'b0, 1'b0);
    step("dec_0002", 1'b1, C_NONE, 2, 1'b1, 1'b0, 1'b0);
    step("dec_0001", 1'b1, C_NONE, 1, 1'b1, 1'b0, 1'b0);
    step("terminal", 1'b1, C_NONE, 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      step("done_hold", 1'b1, C_NONE, 0, 1'b0, 1'b1, 1'b0);
    step("done_start_ign", 1'b0, C_START, 0, 1'b0, 1'b1, 1'b0);

    // ce+stop pauses without decrement; start+ce resumes without decrement
    set_preset(4'd0, 4'd0, 4'd1, 4'd0);
    step("load_from_done", 1'b0, C_LOAD, 10, 1'b0, 1'b0, 1'b0);
    step("start_0010", 1'b0, C_START, 10, 1'b1, 1'b0, 1'b0);
    step("ce_stop", 1'b1, C_STOP, 10, 1'b0, 1'b0, 1'b0);
    step("ce_in_pause", 1'b1, C_NONE, 10, 1'b0, 1'b0, 1'b0);
    step("ce_start_pause", 1'b1, C_START, 10, 1'b1, 1'b0, 1'b0);
    step("dec_0009", 1'b1, C_NONE, 9, 1'b1, 1'b0, 1'b0);
    set_preset(4'd3, 4'd3, 4'd3, 4'd3);
    step("ce_load_in_run", 1'b1, C_LOAD, 8, 1'b1, 1'b0, 1'b0);
    step("dec_borrow_min", 1'b0, C_NONE, 8, 1'b1, 1'b0, 1'b0);

    // Clamped load and start refused at 00:00
    step("clear_b", 1'b0, C_CLEAR, 0, 1'b0, 1'b0, 1'b0);
    set_preset(4'hF, 4'hF, 4'hF, 4'hF);
    step("load_clamp", 1'b0, C_LOAD, 3599, 1'b0, 1'b0, 1'b0);
    step("start_5959", 1'b0, C_START, 3599, 1'b1, 1'b0, 1'b0);
    step("dec_5958", 1'b1, C_NONE, 3598, 1'b1, 1'b0, 1'b0);
    step("clear_c", 1'b0, C_CLEAR, 0, 1'b0, 1'b0, 1'b0);
    step("start_at_zero", 1'b0, C_START, 0, 1'b0, 1'b0, 1'b0);
    step("ce_in_idle", 1'b1, C_NONE, 0, 1'b0, 1'b0, 1'b0);

    // Minute borrow across 10:00 -> 09:59
    set_preset(4'd1, 4'd0, 4'd0, 4'd0);
    step("load_1000", 1'b0, C_LOAD, 600, 1'b0, 1'b0, 1'b0);
    step("start_1000", 1'b0, C_START, 600, 1'b1, 1'b0, 1'b0);
    step("dec_0959", 1'b1, C_NONE, 599, 1'b1, 1'b0, 1'b0);

    // ce+clear at 00:01 in RUN: no alarm, no done
    set_preset(4'd0, 4'd0, 4'd0, 4'd1);
    step("stop_1", 1'b0, C_STOP, 599, 1'b0, 1'b0, 1'b0);
    step("load_0001", 1'b0, C_LOAD, 1, 1'b0, 1'b0, 1'b0);
    step("start_0001", 1'b0, C_START, 1, 1'b1, 1'b0, 1'b0);
    step("ce_clear", 1'b1, C_CLEAR, 0, 1'b0, 1'b0, 1'b0);
    step("after_ce_clear", 1'b1, C_NONE, 0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in RUN at 12:34
    set_preset(4'd1, 4'd2, 4'd3, 4'd5);
    step("load_1235", 1'b0, C_LOAD, 755, 1'b0, 1'b0, 1'b0);
    step("start_1235", 1'b0, C_START, 755, 1'b1, 1'b0, 1'b0);
    step("dec_1234", 1'b0, C_NONE, 755, 1'b1, 1'b0, 1'b0);
    step("dec_1234b", 1'b1, C_NONE, 754, 1'b1, 1'b0, 1'b0);
    ce = 1'b1;
    #2;
    rst_n = 1'b0;
    exp_q.push_back(pack_exp(0, 1'b0, 1'b0, 1'b0));
    #1;
    e = exp_q.pop_front();
    chk("async_reset", observed(), e);
    @(posedge clk);
    #1;
    exp_q.push_back(pack_exp(0, 1'b0, 1'b0, 1'b0));
    e = exp_q.pop_front();
    chk("reset_held", observed(), e);
    rst_n = 1'b1;
    step("post_reset_ce", 1'b1, C_NONE, 0, 1'b0, 1'b0, 1'b0);

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0",
               exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
